// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch front end: PC generation, single outstanding read, instruction FIFO
// Optional feature macro: FETCH_ADDRCHK_EN (compare returned word address against the issued PC)
module ifetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_re,
   input  logic [31:0] i_mem_data,
   input  logic [31:0] i_mem_read_addr,
   input  logic        i_mem_stall,
   input  logic        i_mem_valid,
   input  logic        i_mem_error,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_inst,
   output logic [31:0] o_pc,
   output logic        o_fault,
   output logic        o_valid,
   input  logic        i_ready
);
   localparam int            PW    = $clog2(QDEPTH);
   localparam int            CW    = PW + 1;
   localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

   state_t        state, state_nxt;
   logic [31:0]   pc;
   logic [31:0]   issued_pc;
   logic          outstanding;
   logic [64:0]   fifo_mem [QDEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] free_slots;
   logic          resp_accept;
   logic          addr_bad;
   logic          issue;
   logic          push;
   logic          pop;
   logic [64:0]   push_entry;
   logic [64:0]   head;

   // a response is only meaningful while our single read is in flight
   assign resp_accept = outstanding && !i_mem_stall && i_mem_valid;
   assign free_slots  = DEPTH - count;

`ifdef FETCH_ADDRCHK_EN
   // a bus error already produces a fault entry, so the address check stands aside
   assign addr_bad = (i_mem_read_addr != issued_pc) && !i_mem_error;
`else
   logic unused_read_addr;
   assign unused_read_addr = ^i_mem_read_addr;
   assign addr_bad         = 1'b0;
`endif

   // next state, issue decision and FIFO push entry; redirect overrides everything
   always_comb begin
      state_nxt  = state;
      issue      = 1'b0;
      push       = 1'b0;
      push_entry = {32'h0, issued_pc, 1'b1};
      if (i_redirect) begin
         state_nxt = (outstanding && !resp_accept) ? ST_DRAIN : ST_RUN;
      end else begin
         case (state)
            ST_RUN: begin
               if (resp_accept) begin
                  push = 1'b1;
                  if (i_mem_error || addr_bad) begin
                     state_nxt = ST_HALT;
                  end else begin
                     push_entry = {i_mem_data, issued_pc, 1'b0};
                  end
               end else if (!outstanding && (free_slots != '0)) begin
                  if (pc[1:0] != 2'b00) begin
                     push       = 1'b1;
                     push_entry = {32'h0, pc, 1'b1};
                     state_nxt  = ST_HALT;
                  end else if (!i_mem_stall) begin
                     issue = 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (resp_accept) begin
                  state_nxt = ST_RUN;
               end
            end
            ST_HALT: begin
               state_nxt = ST_HALT;
            end
            default: begin
               state_nxt = ST_RUN;
            end
         endcase
      end
   end

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // fetch PC and the in-flight read bookkeeping
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc          <= RESET_PC;
         issued_pc   <= 32'h0;
         outstanding <= 1'b0;
      end else begin
         if (i_redirect) begin
            pc <= i_redirect_pc;
         end else if (issue) begin
            pc <= pc + 32'd4;
         end
         if (issue) begin
            outstanding <= 1'b1;
            issued_pc   <= pc;
         end else if (resp_accept) begin
            outstanding <= 1'b0;
         end
      end
   end

   assign pop = o_valid && i_ready && !i_redirect;

   // FIFO pointers and occupancy; a redirect empties the queue in one edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_redirect) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage: {inst, pc, fault}
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= push_entry;
      end
   end

   assign head       = fifo_mem[rd_ptr];
   assign o_valid    = (count != '0);
   assign o_inst     = o_valid ? head[64:33] : 32'h0;
   assign o_pc       = o_valid ? head[32:1]  : 32'h0;
   assign o_fault    = o_valid ? head[0]     : 1'b0;
   assign o_mem_addr = pc;
   assign o_mem_re   = issue && !i_rst;
endmodule

// File: tb/tb_ifetch_stage.sv
// tb/tb_ifetch_stage.sv - scoreboard testbench for ifetch_stage
module tb_ifetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_data;
   logic [31:0] mem_raddr;
   logic        mem_stall;
   logic        mem_valid;
   logic        mem_error;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        fault;
   logic        valid;
   logic        ready;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp   = 0;
   int   n_bad   = 0;
   int   n_deliv = 0;
   int   n_reads = 0;
   int   cur     = 0;

   // slave configuration and state
   int          lat        = 0;
   logic [31:0] err_addr   = 32'hFFFF_FFFF;
   logic [31:0] alias_addr = 32'hFFFF_FFFF;
   logic        sl_pend;
   int          sl_cnt;
   logic [31:0] sl_addr;
   logic        re_seen;
   logic [31:0] addr_seen;

   ifetch_stage #(.RESET_PC(32'h0000_0100), .QDEPTH(2)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .o_mem_addr      (mem_addr),
      .o_mem_re        (mem_re),
      .i_mem_data      (mem_data),
      .i_mem_read_addr (mem_raddr),
      .i_mem_stall     (mem_stall),
      .i_mem_valid     (mem_valid),
      .i_mem_error     (mem_error),
      .i_redirect      (redirect),
      .i_redirect_pc   (redirect_pc),
      .o_inst          (inst),
      .o_pc            (pc),
      .o_fault         (fault),
      .o_valid         (valid),
      .i_ready         (ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_ok(input logic [31:0] p);
      exp_t e;
      e.pc = p; e.inst = p ^ 32'hAAAA_0000; e.fault = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic expect_fault(input logic [31:0] p);
      exp_t e;
      e.pc = p; e.inst = 32'h0; e.fault = 1'b1;
      exp_q.push_back(e);
   endtask

   // wait until just after the negative edge of cycle k (cycle 1 = first cycle after reset release)
   task automatic mid(input int k);
      while (cur < k) begin
         @(negedge clk);
         #1;
      end
   endtask

   // wait until just after the rising edge that starts cycle k
   task automatic start(input int k);
      while (cur < k - 1) begin
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      ready       = 1'b0;
      mem_stall   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete();
      n_reads    = 0;
      n_deliv    = 0;
      lat        = 0;
      err_addr   = 32'hFFFF_FFFF;
      alias_addr = 32'hFFFF_FFFF;
      check("rst_mem_addr", mem_addr, 32'h0000_0100);
      check("rst_re_valid_fault", {29'h0, mem_re, valid, fault}, 32'h0);
      check("rst_inst", inst, 32'h0);
      check("rst_pc", pc, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // memory slave: fixed latency, returns addr ^ 0xAAAA0000
   initial begin
      mem_valid = 1'b0;
      mem_data  = 32'h0;
      mem_raddr = 32'h0;
      mem_error = 1'b0;
      sl_pend   = 1'b0;
      sl_cnt    = 0;
      sl_addr   = 32'h0;
      forever begin
         @(negedge clk);
         re_seen   = mem_re;
         addr_seen = mem_addr;
         @(posedge clk);
         #1;
         if (rst) begin
            sl_pend   = 1'b0;
            mem_valid = 1'b0;
         end else begin
            if (mem_valid) begin
               sl_pend   = 1'b0;
               mem_valid = 1'b0;
            end else if (sl_pend && sl_cnt > 0) begin
               sl_cnt--;
            end
            if (re_seen) begin
               sl_pend = 1'b1;
               sl_cnt  = lat;
               sl_addr = addr_seen;
            end
            if (sl_pend && sl_cnt == 0) begin
               mem_valid = 1'b1;
               mem_data  = sl_addr ^ 32'hAAAA_0000;
               mem_error = (sl_addr == err_addr);
               mem_raddr = (sl_addr == alias_addr) ? 32'h0000_0104 : sl_addr;
            end
         end
      end
   end

   // monitor: counts reads and checks every accepted instruction against the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            cur = 0;
         end else begin
            cur++;
            if (mem_re) n_reads++;
            if (valid && ready && !redirect) begin
               n_deliv++;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL sb_unexpected: got pc %h inst %h fault %b, expected no delivery", pc, inst, fault);
               end else begin
                  e = exp_q.pop_front();
                  if (pc !== e.pc || inst !== e.inst || fault !== e.fault) begin
                     n_bad++;
                     $display("FAIL sb_entry: got pc %h inst %h fault %b, expected pc %h inst %h fault %b",
                              pc, inst, fault, e.pc, e.inst, e.fault);
                  end
               end
            end
         end
      end
   end

   initial begin
      // nominal streaming, zero-wait slave
      do_reset();
      ready = 1'b1;
      for (int i = 0; i < 9; i++) expect_ok(32'h100 + 32'(i * 4));
      mid(1);
      check("t1_first_re", {31'h0, mem_re}, 32'h1);
      check("t1_first_addr", mem_addr, 32'h0000_0100);
      start(21);
      ready = 1'b0;
      check("t1_deliv", n_deliv, 9);
      check("t1_reads", n_reads, 10);
      check("t1_q_empty", exp_q.size(), 0);

      // backpressure fills QDEPTH=2
      do_reset();
      mid(5);
      check("t2_reads5", n_reads, 2);
      check("t2_head_pc5", pc, 32'h0000_0100);
      check("t2_head_inst5", inst, 32'hAAAA_0100);
      mid(10);
      check("t2_reads10", n_reads, 2);
      check("t2_head_pc10", pc, 32'h0000_0100);
      check("t2_valid10", {31'h0, valid}, 32'h1);
      expect_ok(32'h100); expect_ok(32'h104); expect_ok(32'h108);
      start(11);
      ready = 1'b1;
      mid(12);
      check("t2_resume_re", {31'h0, mem_re}, 32'h1);
      check("t2_resume_addr", mem_addr, 32'h0000_0108);
      start(15);
      ready = 1'b0;
      check("t2_deliv", n_deliv, 3);
      check("t2_q_empty", exp_q.size(), 0);

      // redirect while the read of 0x10C is in flight, 3-cycle slave
      do_reset();
      lat   = 2;
      ready = 1'b1;
      expect_ok(32'h100); expect_ok(32'h104); expect_ok(32'h108);
      start(14);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_2000;
      expect_ok(32'h2000);
      start(15);
      redirect = 1'b0;
      mid(15);
      check("t3_drain_re15", {31'h0, mem_re}, 32'h0);
      check("t3_empty15", {31'h0, valid}, 32'h0);
      mid(16);
      check("t3_drain_re16", {31'h0, mem_re}, 32'h0);
      mid(17);
      check("t3_new_re", {31'h0, mem_re}, 32'h1);
      check("t3_new_addr", mem_addr, 32'h0000_2000);
      check("t3_dropped", {31'h0, valid}, 32'h0);
      start(22);
      ready = 1'b0;
      check("t3_deliv", n_deliv, 4);
      check("t3_reads", n_reads, 6);
      check("t3_q_empty", exp_q.size(), 0);

      // bus error on 0x108, then redirect to 0x300
      do_reset();
      err_addr = 32'h0000_0108;
      ready    = 1'b1;
      expect_ok(32'h100); expect_ok(32'h104); expect_fault(32'h108);
      mid(11);
      check("t4_halt_reads", n_reads, 3);
      check("t4_halt_valid", {31'h0, valid}, 32'h0);
      start(12);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      expect_ok(32'h300);
      start(13);
      redirect = 1'b0;
      mid(13);
      check("t4_resume_re", {31'h0, mem_re}, 32'h1);
      check("t4_resume_addr", mem_addr, 32'h0000_0300);
      start(16);
      ready = 1'b0;
      check("t4_deliv", n_deliv, 4);
      check("t4_q_empty", exp_q.size(), 0);

      // misaligned redirect target
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0302;
      expect_fault(32'h302);
      start(2);
      redirect = 1'b0;
      mid(4);
      check("t5_valid", {31'h0, valid}, 32'h1);
      check("t5_pc", pc, 32'h0000_0302);
      check("t5_fault_inst", {fault, inst[30:0]}, 32'h8000_0000);
      check("t5_reads4", n_reads, 0);
      start(5);
      ready = 1'b1;
      mid(8);
      check("t5_halt_valid", {31'h0, valid}, 32'h0);
      check("t5_reads8", n_reads, 0);
      check("t5_deliv", n_deliv, 1);
      check("t5_q_empty", exp_q.size(), 0);

      // returned address 0x104 for the read of 0x108
      do_reset();
      alias_addr = 32'h0000_0108;
      ready      = 1'b1;
`ifdef FETCH_ADDRCHK_EN
      expect_ok(32'h100); expect_ok(32'h104); expect_fault(32'h108);
      start(10);
      ready = 1'b0;
      check("t6_deliv", n_deliv, 3);
      check("t6_reads", n_reads, 3);
`else
      expect_ok(32'h100); expect_ok(32'h104); expect_ok(32'h108); expect_ok(32'h10C);
      start(10);
      ready = 1'b0;
      check("t6_deliv", n_deliv, 4);
      check("t6_reads", n_reads, 5);
`endif
      check("t6_q_empty", exp_q.size(), 0);

      // adapter stall blocks issue; reset then lands on an in-flight read
      do_reset();
      mem_stall = 1'b1;
      mid(4);
      check("t7_stall_reads", n_reads, 0);
      check("t7_stall_re", {31'h0, mem_re}, 32'h0);
      start(5);
      mem_stall = 1'b0;
      mid(5);
      check("t7_re", {31'h0, mem_re}, 32'h1);
      check("t7_addr", mem_addr, 32'h0000_0100);
      do_reset();
      mid(3);
      check("t7_after_reset_reads", n_reads, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
